bit4_adder_sub: RTL and testbench
=================================

BIT4_ADDER_SUB -- requirements
Module: bit4_adder_sub

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 4 by package constant ADDSUB_W = 4.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 M  input  1  mode: 0 = add (A+B), 1 = subtract (A-B).
REQ-006 a0..a3  input  1 each  operand A; a0 = LSB, a3 = MSB/sign.
REQ-007 b0..b3  input  1 each  operand B; b0 = LSB, b3 = MSB/sign.
REQ-008 C  output  1  registered carry-out of bit 3.
REQ-009 S0..S3  output  1 each  registered result; S0 = LSB.
REQ-010 V  output  1  registered two's-complement overflow flag.

Function
REQ-011 The block SHALL form B' = B XOR {4{M}} and carry-in c0 = M, so that M=1 computes A + ~B + 1.
REQ-012 The datapath SHALL be a 4-stage ripple chain of full adders; c(i+1) is the carry out of stage i.
REQ-013 The result SHALL be S = (A + B' + c0) mod 16, with C = c4.
REQ-014 V SHALL equal c3 XOR c4.
REQ-015 In subtract mode, C=1 SHALL mean no borrow (A >= B unsigned), and C=0 SHALL mean borrow.
REQ-016 Operands SHALL be sampled on every rising clk.
REQ-017 C, S and V SHALL update together one cycle after sampling; latency is 1 cycle and throughput is 1 result per cycle.
REQ-018 There SHALL be no handshake; a new result is produced every cycle.
REQ-019 A change of M takes effect on the very next capture, with no pipeline flush.
REQ-020 Unsigned wrap-around (15+1 -> 0, C=1) and signed overflow (7+1 -> -8, V=1) SHALL be reported, never saturated.

Reset
REQ-021 While rst=1, C, S0..S3 and V SHALL be 0 immediately, independent of clk.
REQ-022 After rst deasserts, the first rising clk SHALL capture the current inputs.
REQ-023 A reset asserted mid-operation SHALL discard the in-flight result.

Configuration
REQ-024 The macro ADDSUB_ZERO_FLAG_EN SHALL control an optional zero flag.
REQ-025 With ADDSUB_ZERO_FLAG_EN defined, the block SHALL have an extra output Z (1 bit, last in the port list), registered with the other outputs, equal to 1 when S == 0.
REQ-026 Z SHALL reset to 0.
REQ-027 Without ADDSUB_ZERO_FLAG_EN, port Z and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package bit4_adder_sub_pkg SHALL hold ADDSUB_W and the mode constants MODE_ADD = 0 and MODE_SUB = 1.
REQ-029 Sub-module full_adder SHALL have ports (a, b, cin, sum, cout) and be instantiated 4 times; the top level holds the B XOR M logic, the overflow logic and the output registers.

Verification
REQ-030 Reset: rst=1 with any inputs -> C=0, S=0000, V=0 without a clock edge.
REQ-031 Add case: M=0, A=1101, B=0010, then one clk -> S=1111, C=0, V=0.
REQ-032 Unsigned wrap: M=0, A=1111, B=0001 -> S=0000, C=1, V=0 (Z=1 if enabled).
REQ-033 Subtract: M=1, A=1111, B=0001 -> S=1110, C=1, V=0.
REQ-034 Signed overflow, add and subtract:
  - M=0, A=0111, B=0001 -> S=1000, C=0, V=1.
  - M=1, A=1000, B=0001 -> S=0111, C=1, V=1.
REQ-035 Borrow and latency: M=1, A=0000, B=0001 -> S=1111, C=0, V=0.
  - Outputs SHALL hold their previous value until the next rising clk.
  - Back-to-back vectors SHALL each appear exactly 1 cycle later.

Source files
------------

// File: rtl/bit4_adder_sub_pkg.sv
// Shared constants and result bundle for the 4-bit adder/subtractor.
// Optional zero flag in the top is enabled by ADDSUB_ZERO_FLAG_EN.
package bit4_adder_sub_pkg;

  localparam int ADDSUB_W = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic                c;
    logic [ADDSUB_W-1:0] s;
    logic                v;
  } addsub_res_t;

  // Two's-complement overflow: carry into MSB differs from carry out.
  function automatic logic ovf_flag(
    input logic c_msb_in,
    input logic c_msb_out
  );
    return c_msb_in ^ c_msb_out;
  endfunction

endpackage

// File: rtl/bit4_adder_sub_full_adder.sv
// One-bit full adder, the ripple cell of the adder/subtractor.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  // Sum and carry from propagate/generate terms.
  always_comb begin
    p    = a ^ b;
    sum  = p ^ cin;
    cout = (a & b) | (cin & p);
  end

endmodule

// File: rtl/bit4_adder_sub.sv
// Registered 4-bit ripple adder/subtractor with carry and overflow.
// Define ADDSUB_ZERO_FLAG_EN to add a registered zero flag output Z.
module bit4_adder_sub
  import bit4_adder_sub_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic M,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic C,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic V
`ifdef ADDSUB_ZERO_FLAG_EN
  ,
  output logic Z
`endif
);

  logic [ADDSUB_W-1:0] a_vec;
  logic [ADDSUB_W-1:0] b_vec;
  logic [ADDSUB_W-1:0] bx;
  logic [ADDSUB_W-1:0] sum;
  logic [ADDSUB_W:0]   cy;
  logic                sub;

  addsub_res_t res_d;
  addsub_res_t res_q;

  // Gather operands, invert B and seed carry-in for subtract.
  always_comb begin
    sub   = (M == MODE_SUB);
    a_vec = {a3, a2, a1, a0};
    b_vec = {b3, b2, b1, b0};
    bx    = b_vec ^ {ADDSUB_W{sub}};
  end

  assign cy[0] = sub;

  for (genvar i = 0; i < ADDSUB_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a_vec[i]),
      .b    (bx[i]),
      .cin  (cy[i]),
      .sum  (sum[i]),
      .cout (cy[i+1])
    );
  end

  // Next result: sum, final carry and signed overflow.
  always_comb begin
    res_d   = '0;
    res_d.s = sum;
    res_d.c = cy[ADDSUB_W];
    res_d.v = ovf_flag(cy[ADDSUB_W-1], cy[ADDSUB_W]);
  end

  // Capture a new result every cycle; reset clears it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  assign C  = res_q.c;
  assign S0 = res_q.s[0];
  assign S1 = res_q.s[1];
  assign S2 = res_q.s[2];
  assign S3 = res_q.s[3];
  assign V  = res_q.v;

`ifdef ADDSUB_ZERO_FLAG_EN
  logic z_d;
  logic z_q;

  // Zero flag tracks the same captured sum.
  always_comb begin
    z_d = (sum == '0);
  end

  // Registered alongside the main result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) z_q <= 1'b0;
    else     z_q <= z_d;
  end

  assign Z = z_q;
`endif

endmodule

// File: tb/tb_bit4_adder_sub.sv
// Directed bench for bit4_adder_sub.
// Checks {C,S,V} (and Z when ADDSUB_ZERO_FLAG_EN is defined).
module tb_bit4_adder_sub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic M = 1'b0;
  logic a0 = 0, a1 = 0, a2 = 0, a3 = 0;
  logic b0 = 0, b1 = 0, b2 = 0, b3 = 0;
  logic C, S0, S1, S2, S3, V;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic Z;
`endif

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bit4_adder_sub dut (
    .clk (clk),
    .rst (rst),
    .M   (M),
    .a0  (a0),
    .a1  (a1),
    .a2  (a2),
    .a3  (a3),
    .b0  (b0),
    .b1  (b1),
    .b2  (b2),
    .b3  (b3),
    .C   (C),
    .S0  (S0),
    .S1  (S1),
    .S2  (S2),
    .S3  (S3),
    .V   (V)
`ifdef ADDSUB_ZERO_FLAG_EN
    ,
    .Z   (Z)
`endif
  );

  // {C, S3..S0, V}
  function automatic logic [5:0] obs();
    return {C, S3, S2, S1, S0, V};
  endfunction

  task automatic chk(
    input string      tag,
    input logic [5:0] got,
    input logic [5:0] exp
  );
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b want=%b", tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic       m,
    input logic [3:0] a,
    input logic [3:0] b
  );
    M  = m;
    {a3, a2, a1, a0} = a;
    {b3, b2, b1, b0} = b;
  endtask

  typedef struct {
    string      tag;
    logic       m;
    logic [3:0] a;
    logic [3:0] b;
    logic [5:0] exp;
  } vec_t;

  // exp = {C, S[3:0], V}, hand-computed
  vec_t vt[8];

  initial begin
    vt[0] = '{"add13p2",  1'b0, 4'b1101, 4'b0010, 6'b0_1111_0};
    vt[1] = '{"wrap15p1", 1'b0, 4'b1111, 4'b0001, 6'b1_0000_0};
    vt[2] = '{"sub15m1",  1'b1, 4'b1111, 4'b0001, 6'b1_1110_0};
    vt[3] = '{"ovf7p1",   1'b0, 4'b0111, 4'b0001, 6'b0_1000_1};
    vt[4] = '{"ovfm8m1",  1'b1, 4'b1000, 4'b0001, 6'b1_0111_1};
    vt[5] = '{"brw0m1",   1'b1, 4'b0000, 4'b0001, 6'b0_1111_0};
    vt[6] = '{"sub5m3",   1'b1, 4'b0101, 4'b0011, 6'b1_0010_0};
    vt[7] = '{"sub3m5",   1'b1, 4'b0011, 4'b0101, 6'b0_1110_0};

    // Async reset with no edge: outputs zero immediately.
    drive(1'b0, 4'b1111, 4'b1111);
    #2 rst = 1'b1;
    #1 chk("rst_async", obs(), 6'b0);
`ifdef ADDSUB_ZERO_FLAG_EN
    chk("rst_z", {5'b0, Z}, 6'b0);
`endif
    @(posedge clk); #1;
    chk("rst_hold", obs(), 6'b0);
    @(negedge clk) rst = 1'b0;

    // First edge after release captures current inputs.
    drive(vt[0].m, vt[0].a, vt[0].b);
    @(posedge clk); #1;
    chk("first_cap", obs(), vt[0].exp);

    // Output holds while inputs change mid-cycle.
    @(negedge clk) drive(vt[1].m, vt[1].a, vt[1].b);
    #2 chk("hold", obs(), vt[0].exp);
    @(posedge clk); #1;
    chk(vt[1].tag, obs(), vt[1].exp);
`ifdef ADDSUB_ZERO_FLAG_EN
    chk("z_wrap", {5'b0, Z}, 6'd1);
`endif

    // Back-to-back vectors, mode switching each cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) drive(vt[i].m, vt[i].a, vt[i].b);
      @(posedge clk); #1;
      chk(vt[i].tag, obs(), vt[i].exp);
`ifdef ADDSUB_ZERO_FLAG_EN
      chk("z_b2b", {5'b0, Z}, {5'b0, (vt[i].exp[4:1] == 4'b0)});
`endif
    end

    // Reset mid-operation discards the in-flight result.
    @(negedge clk) drive(vt[3].m, vt[3].a, vt[3].b);
    rst = 1'b1;
    #1 chk("rst_mid", obs(), 6'b0);
    @(posedge clk); #1;
    chk("rst_mid_edge", obs(), 6'b0);
    @(negedge clk) begin
      rst = 1'b0;
      drive(vt[4].m, vt[4].a, vt[4].b);
    end
    @(posedge clk); #1;
    chk("post_rst", obs(), vt[4].exp);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
